// File: rtl/alu_dec_pipe.sv
// Registered, handshaked ALU-control decoder for the MIPS execute stage.
// Decodes opcode/funct into an ALU control word plus immediate/mult-div/illegal
// flags with one cycle of latency, and holds off upstream while the iterative
// mult/div unit is busy after a mult/div word issues.
module alu_dec_pipe #(
  parameter int CTRL_W     = 4,
  parameter int MULDIV_LAT = 4,
  parameter bit EN_IMM     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_alu_ctrl,
  output logic              out_imm,
  output logic              out_muldiv,
  output logic              out_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_NOR   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_MULT  = 4'd11,
    ALU_MULTU = 4'd12,
    ALU_DIV   = 4'd13,
    ALU_DIVU  = 4'd14,
    ALU_LUI   = 4'd15
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int CNT_W = (MULDIV_LAT > 0) ? $clog2(MULDIV_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MULDIV_LAT);

  logic [5:0]       opcode;
  logic [5:0]       funct;
  alu_op_e          dec_op;
  logic             dec_imm;
  logic             dec_muldiv;
  logic             dec_illegal;
  logic             accept;
  logic             xfer;
  state_e           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic             unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:6];

  // Instruction decode: opcode first, R-type resolved by funct.
  always_comb begin
    dec_op      = ALU_ADD;
    dec_imm     = 1'b0;
    dec_muldiv  = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000, 6'b100001: dec_op = ALU_ADD;
          6'b100010, 6'b100011: dec_op = ALU_SUB;
          6'b100100:            dec_op = ALU_AND;
          6'b100101:            dec_op = ALU_OR;
          6'b100110:            dec_op = ALU_XOR;
          6'b100111:            dec_op = ALU_NOR;
          6'b101010:            dec_op = ALU_SLT;
          6'b101011:            dec_op = ALU_SLTU;
          6'b000000:            dec_op = ALU_SLL;
          6'b000010:            dec_op = ALU_SRL;
          6'b000011:            dec_op = ALU_SRA;
          6'b011000: begin dec_op = ALU_MULT;  dec_muldiv = 1'b1; end
          6'b011001: begin dec_op = ALU_MULTU; dec_muldiv = 1'b1; end
          6'b011010: begin dec_op = ALU_DIV;   dec_muldiv = 1'b1; end
          6'b011011: begin dec_op = ALU_DIVU;  dec_muldiv = 1'b1; end
          default:              dec_illegal = 1'b1;
        endcase
      end
      6'b100011, 6'b101011: begin
        dec_op  = ALU_ADD;
        dec_imm = 1'b1;
      end
      6'b000100, 6'b000101: dec_op = ALU_SUB;
      // I-type ALU group 001xxx: low three opcode bits select the operation.
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        if (EN_IMM) begin
          dec_imm = 1'b1;
          case (opcode[2:0])
            3'b000, 3'b001: dec_op = ALU_ADD;
            3'b010:         dec_op = ALU_SLT;
            3'b011:         dec_op = ALU_SLTU;
            3'b100:         dec_op = ALU_AND;
            3'b101:         dec_op = ALU_OR;
            3'b110:         dec_op = ALU_XOR;
            default:        dec_op = ALU_LUI;
          endcase
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign xfer     = out_valid & out_ready;
  assign in_ready = ~flush & (state == IDLE) & ~(out_valid & out_muldiv)
                  & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Busy-tracking state and countdown registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  // Enter BUSY on a mult/div issue (flush does not cancel it); leave when the count expires.
  always_comb begin
    state_n = state;
    count_n = count;
    case (state)
      IDLE: begin
        if (xfer && out_muldiv && (MULDIV_LAT > 0)) begin
          state_n = BUSY;
          count_n = LAT_CNT;
        end
      end
      BUSY: begin
        count_n = count - CNT_W'(1);
        if (count_n == '0) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  // Output register: flush drops the valid but keeps the last decoded fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_alu_ctrl <= '0;
      out_imm      <= 1'b0;
      out_muldiv   <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_alu_ctrl <= CTRL_W'(dec_op);
      out_imm      <= dec_imm;
      out_muldiv   <= dec_muldiv;
      out_illegal  <= dec_illegal;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule
